// File: rtl/if_id_queue_pkg.sv
// Shared types and helpers for the IF->ID fetch queue.
// Holds the entry layout, the zero word and the DEPTH legality check.
package if_id_queue_pkg;

   localparam int IFQ_ADDR_W = 32;
   localparam int IFQ_INST_W = 32;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   typedef struct packed {
      logic [IFQ_ADDR_W-1:0] pc;
      logic [IFQ_INST_W-1:0] inst;
      logic                  taken;
   } ifq_entry_t;

   // Pointers wrap by natural overflow, so DEPTH must be a power of two.
   function automatic bit depth_ok(input int d);
      return (d >= 2) && ((d & (d - 1)) == 0);
   endfunction

endpackage

// File: rtl/ifq_ram.sv
// DEPTH x W register array for the fetch queue: one write port, async read.
// Storage is not reset; the queue top masks the read data when empty.
module ifq_ram #(
   parameter int DEPTH = 4,
   parameter int W     = 65,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode FIFO with valid/ready on both sides and single-cycle flush.
// Optional backpressure statistics counter enabled by defining IFQ_STATS_EN.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_pc,
   input  logic [INST_W-1:0]        in_inst,
   input  logic                     in_taken,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_W-1:0]        out_pc,
   output logic [INST_W-1:0]        out_inst,
   output logic                     out_taken,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [31:0]              stat_bp_cycles
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_W + INST_W + 1;
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   if (!depth_ok(DEPTH)) begin : g_depth_illegal
      $error("if_id_queue: DEPTH must be a power of two >= 2");
   end

   typedef struct packed {
      logic              taken;
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          push, pop;
   entry_t        wr_entry, rd_entry;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. in_ready comes only from registered state (no out_ready path),
   // so a full queue refuses a push even in a cycle that pops.
   assign in_ready  = !rst && (count != FullCount);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign wr_entry = '{taken: in_taken, inst: in_inst, pc: in_pc};

   ifq_ram #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (push && !flush),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Empty queue shows a bubble rather than whatever the RAM last held.
   assign out_pc    = out_valid ? rd_entry.pc    : '0;
   assign out_inst  = out_valid ? rd_entry.inst  : '0;
   assign out_taken = out_valid ? rd_entry.taken : 1'b0;
   assign occupancy = count;

`ifdef IFQ_STATS_EN
   logic [31:0] bp_cnt;

   // Saturating; flush deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         bp_cnt <= ZeroWord;
      end else if (in_valid && !in_ready && (bp_cnt != ~ZeroWord)) begin
         bp_cnt <= bp_cnt + 32'd1;
      end
   end

   assign stat_bp_cycles = bp_cnt;
`else
   assign stat_bp_cycles = ZeroWord;
`endif

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised fetch-to-decode buffer between the IF and ID stages. Holds up to DEPTH fetched instructions, each with its PC and predicted-taken bit, in FIFO order. Uses valid/ready handshakes on both sides instead of stall bits, and supports a single-cycle flush on redirect. When DEPTH=1 is excluded, it replaces the fixed one-entry IF/ID latch and lets IF run ahead of a stalled ID.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- ADDR_W, 32, PC width
- INST_W, 32, instruction width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries and any same-cycle push (branch/jump redirect)
- in_valid  in  1  IF presents an entry
- in_ready  out  1  queue can accept an entry
- in_pc  in  ADDR_W  PC of incoming instruction
- in_inst  in  INST_W  incoming instruction
- in_taken  in  1  predictor taken bit
- out_valid  out  1  head entry available to ID
- out_ready  in  1  ID consumes head this cycle
- out_pc  out  ADDR_W  head PC
- out_inst  out  INST_W  head instruction
- out_taken  out  1  head taken bit
- occupancy  out  $clog2(DEPTH)+1  current entry count
- stat_bp_cycles  out  32  backpressure cycle counter (IFQ_STATS_EN only)

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: circular array; rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; count is $clog2(DEPTH)+1 bits.
- in_ready = !rst & (count != DEPTH). Depends only on registered state, so there is no combinational path from out_ready. A full queue does not accept an entry even when a pop occurs in the same cycle.
- out_valid = (count != 0). When count == 0, out_pc, out_inst and out_taken are driven to 0 (bubble), never stale data.
- Priority per edge: rst > flush > push/pop.
  - rst: ptrs and count set to 0.
  - flush: ptrs and count set to 0; same-cycle push and pop have no effect.
- Push only: write at wr_ptr, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count−1.
- Push and pop together (count in 1..DEPTH−1): both pointers advance and count is unchanged.
- Push into an empty queue is not visible at the output in the same cycle; there is no bypass.

## Timing
- Reset values:
  - out_valid=0
  - out_pc/out_inst/out_taken=0
  - occupancy=0
  - in_ready=0 while rst is high, 1 on the first cycle after
  - stat_bp_cycles=0
- Latency: entry pushed at edge N appears on out_* after edge N, giving 1-cycle minimum latency.
- Throughput: 1 entry/cycle sustained when out_ready is held high.
- Flush at edge N: out_valid=0 and in_ready=1 after edge N; new pushes are accepted from the cycle after.
- A rst that arrives mid-stream drops all entries identically to flush, and also clears the stats counter.

## Configuration
- IFQ_STATS_EN defined: stat_bp_cycles increments on every cycle with in_valid & !in_ready. It saturates at 32'hFFFF_FFFF, is cleared only by rst, and is unaffected by flush.
- IFQ_STATS_EN undefined: stat_bp_cycles port still exists and is tied to 0; no counter logic is synthesised.

## Structure
- Shared package:
  - ifq_entry_t (pc, inst, taken), packed
  - ZeroWord constant
  - DEPTH legality check helper
- Sub-module ifq_ram: DEPTH×entry register array.
  - Write port: wr_en, wr_addr, wr_data.
  - Asynchronous read at rd_addr.
  - No reset on storage; the top level masks output when empty.

## Test plan
- Reset then idle: out_valid=0, occupancy=0, out_inst=0; in_ready=1 on the first cycle after rst deasserts.
- Push PCs 0x100, 0x104, 0x108, 0x10C with out_ready=0 (DEPTH=4):
  - occupancy reaches 4 and in_ready=0.
  - A fifth in_valid is not accepted.
  - With IFQ_STATS_EN, stat_bp_cycles increments by 1 per held cycle.
- Full queue with out_ready=1 and in_valid=1:
  - Cycle 1: pop 0x100, no push, occupancy=3.
  - Next cycle: push and pop together, occupancy stays 3.
- Streaming 8 entries with out_ready=1 throughout:
  - Outputs appear in order, one cycle after each push.
  - Pointers wrap past index 3 without loss or duplication.
- Flush with 3 entries queued while in_valid=1 and out_ready=1 in the same cycle:
  - Next cycle occupancy=0 and out_valid=0.
  - Neither the pushed nor the popped entry reappears.
  - stat_bp_cycles is unchanged.
- Assert rst with 2 entries queued: all outputs return to reset values, and stat_bp_cycles=0.
